// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, optional one-entry skid buffer,
// flush-to-NOP and a saturating stall counter. All state moves on the falling clock edge.
module if_id_pipe_reg #(
   parameter int unsigned             PC_W      = 16,
   parameter int unsigned             INSTR_W   = 16,
   parameter logic [INSTR_W-1:0]      NOP_INSTR = '0,
   parameter bit                      SKID      = 1'b1,
   parameter int unsigned             CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    PC_plus_two,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               flush,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [PC_W-1:0]    O_PC_plus_two,
   output logic [INSTR_W-1:0] O_instruction,
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_MAIN  = 2'd1,
      S_BOTH  = 2'd2
   } occ_e;

   occ_e               state_q, state_d;
   logic [PC_W-1:0]    main_pc_q, main_pc_d;
   logic [INSTR_W-1:0] main_ins_q, main_ins_d;
   logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0] skid_ins_q, skid_ins_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rdy_q, rdy_d;

   logic main_valid;
   logic skid_valid;
   logic main_free;
   logic in_fire;

   assign main_valid = (state_q != S_EMPTY);
   assign skid_valid = (state_q == S_BOTH);
   assign main_free  = !main_valid || out_ready;

   // With a skid entry, ready comes straight from a flop so fetch never sees a comb path from decode.
   assign in_ready = SKID ? rdy_q : main_free;
   assign in_fire  = in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      main_pc_d  = main_pc_q;
      main_ins_d = main_ins_q;
      skid_pc_d  = skid_pc_q;
      skid_ins_d = skid_ins_q;
      cnt_d      = cnt_q;

      if (flush) begin
         state_d    = S_EMPTY;
         main_ins_d = NOP_INSTR;
      end else begin
         if (main_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (main_free) begin
            if (skid_valid) begin
               main_pc_d  = skid_pc_q;
               main_ins_d = skid_ins_q;
               state_d    = S_MAIN;
            end else if (in_fire) begin
               main_pc_d  = PC_plus_two;
               main_ins_d = instruction;
               state_d    = S_MAIN;
            end else begin
               main_ins_d = NOP_INSTR;
               state_d    = S_EMPTY;
            end
         end else if (SKID && in_fire) begin
            skid_pc_d  = PC_plus_two;
            skid_ins_d = instruction;
            state_d    = S_BOTH;
         end
      end

      rdy_d = (state_d != S_BOTH);
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         main_pc_q  <= '0;
         main_ins_q <= NOP_INSTR;
         skid_pc_q  <= '0;
         skid_ins_q <= '0;
         cnt_q      <= '0;
         rdy_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_pc_q  <= main_pc_d;
         main_ins_q <= main_ins_d;
         skid_pc_q  <= skid_pc_d;
         skid_ins_q <= skid_ins_d;
         cnt_q      <= cnt_d;
         rdy_q      <= rdy_d;
      end
   end

   assign out_valid     = main_valid;
   assign O_PC_plus_two = main_pc_q;
   assign O_instruction = main_ins_q;
   assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: skid instance checked against a FIFO scoreboard,
// a SKID=0 / CNT_W=3 instance checked with constants.
module tb_if_id_pipe_reg;

   logic clk = 1'b1;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, flush, out_ready, out_valid;
   logic [15:0] pc, instr, o_pc, o_instr, stall_cnt;

   logic        s_in_valid, s_in_ready, s_flush, s_out_ready, s_out_valid;
   logic [15:0] s_pc, s_instr, s_o_pc, s_o_instr;
   logic [2:0]  s_stall_cnt;

   if_id_pipe_reg u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .PC_plus_two(pc), .instruction(instr), .flush(flush), .out_ready(out_ready),
      .out_valid(out_valid), .O_PC_plus_two(o_pc), .O_instruction(o_instr),
      .stall_cnt(stall_cnt)
   );

   if_id_pipe_reg #(.SKID(1'b0), .CNT_W(3)) u_small (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .PC_plus_two(s_pc), .instruction(s_instr), .flush(s_flush), .out_ready(s_out_ready),
      .out_valid(s_out_valid), .O_PC_plus_two(s_o_pc), .O_instruction(s_o_instr),
      .stall_cnt(s_stall_cnt)
   );

   typedef struct {
      logic [15:0] pc;
      logic [15:0] ins;
   } ent_t;

   ent_t        sb[$];
   logic [15:0] exp_pc;
   int          exp_cnt;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] p, input logic [15:0] i,
                        input logic f, input logic r);
      in_valid  = v;
      pc        = p;
      instr     = i;
      flush     = f;
      out_ready = r;
   endtask

   task automatic sdrive(input logic v, input logic [15:0] p, input logic [15:0] i,
                         input logic f, input logic r);
      s_in_valid  = v;
      s_pc        = p;
      s_instr     = i;
      s_flush     = f;
      s_out_ready = r;
   endtask

   // Advance one falling edge, update the scoreboard from what was driven, check u_dut.
   task automatic tick(input string tag);
      bit   infire, outfire, stall;
      ent_t dummy;
      infire  = in_valid && (sb.size() < 2);
      outfire = (sb.size() > 0) && out_ready;
      stall   = !flush && (sb.size() > 0) && !out_ready;
      @(negedge clk);
      #2;
      if (flush) begin
         sb.delete();
      end else begin
         if (outfire) dummy = sb.pop_front();
         if (infire) sb.push_back('{pc, instr});
      end
      if (stall && exp_cnt < 65535) exp_cnt++;
      if (sb.size() > 0) exp_pc = sb[0].pc;
      chk({tag, ":out_valid"}, 32'(out_valid), 32'(sb.size() > 0));
      chk({tag, ":in_ready"}, 32'(in_ready), 32'(sb.size() < 2));
      chk({tag, ":instr"}, 32'(o_instr), (sb.size() > 0) ? 32'(sb[0].ins) : 32'h0);
      chk({tag, ":pc"}, 32'(o_pc), 32'(exp_pc));
      chk({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      sdrive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      exp_pc  = 16'h0;
      exp_cnt = 0;
      #1;
      chk("rst0:out_valid", 32'(out_valid), 32'h0);
      chk("rst0:instr", 32'(o_instr), 32'h0);
      chk("rst0:in_ready", 32'(in_ready), 32'h1);
      chk("rst0:stall_cnt", 32'(stall_cnt), 32'h0);
      #19 rst = 1'b0;

      // T2 streaming
      for (int unsigned k = 0; k < 4; k++) begin
         drive(1'b1, 16'(2 * (k + 1)), 16'(16'h1001 + k), 1'b0, 1'b1);
         tick("t2");
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      tick("t2drain");

      // T3 stall with skid capture, then release
      drive(1'b1, 16'h0020, 16'hA000, 1'b0, 1'b0);
      tick("t3a");
      drive(1'b1, 16'h0022, 16'hA001, 1'b0, 1'b0);
      tick("t3b");
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick("t3c");
      tick("t3d");
      chk("t3:stall3", 32'(stall_cnt), 32'd3);
      chk("t3:skid_full", 32'(in_ready), 32'h0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      tick("t3rel");
      chk("t3:a001", 32'(o_instr), 32'hA001);
      tick("t3drain");

      // T4 flush with main and skid occupied, concurrent input dropped
      drive(1'b1, 16'h0030, 16'hB000, 1'b0, 1'b0);
      tick("t4a");
      drive(1'b1, 16'h0032, 16'hB001, 1'b0, 1'b0);
      tick("t4b");
      drive(1'b1, 16'h0034, 16'hB002, 1'b1, 1'b0);
      tick("t4flush");
      chk("t4:nop", 32'(o_instr), 32'h0);
      chk("t4:pc_held", 32'(o_pc), 32'h0030);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      tick("t4after");

      // T1 asynchronous reset mid-cycle while holding a live, stalled entry
      drive(1'b1, 16'h0040, 16'hC000, 1'b0, 1'b0);
      tick("t1pre");
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick("t1pre2");
      #4 rst = 1'b1;
      #1;
      chk("t1:out_valid", 32'(out_valid), 32'h0);
      chk("t1:instr", 32'(o_instr), 32'h0);
      chk("t1:stall_cnt", 32'(stall_cnt), 32'h0);
      chk("t1:in_ready", 32'(in_ready), 32'h1);
      chk("t1:pc", 32'(o_pc), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      exp_cnt = 0;
      exp_pc  = 16'h0;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      tick("t1post");

      // T5 SKID=0: comb in_ready
      sdrive(1'b1, 16'h0050, 16'hD000, 1'b0, 1'b1);
      tick("t5a");
      chk("t5:d000", 32'(s_o_instr), 32'hD000);
      chk("t5:valid", 32'(s_out_valid), 32'h1);
      sdrive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      chk("t5:ready_low", 32'(s_in_ready), 32'h0);
      sdrive(1'b1, 16'h0052, 16'hD001, 1'b0, 1'b1);
      #1;
      chk("t5:ready_high", 32'(s_in_ready), 32'h1);
      tick("t5b");
      chk("t5:d001", 32'(s_o_instr), 32'hD001);
      chk("t5:pc", 32'(s_o_pc), 32'h0052);
      chk("t5:cnt0", 32'(s_stall_cnt), 32'h0);

      // T6 saturation at CNT_W=3
      sdrive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      for (int unsigned k = 0; k < 10; k++) begin
         tick("t6");
         if (k == 5) chk("t6:cnt6", 32'(s_stall_cnt), 32'd6);
      end
      chk("t6:sat", 32'(s_stall_cnt), 32'd7);
      sdrive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      tick("t6flush");
      chk("t6:sat_flush", 32'(s_stall_cnt), 32'd7);
      chk("t6:flush_valid", 32'(s_out_valid), 32'h0);
      chk("t6:flush_nop", 32'(s_o_instr), 32'h0);
      chk("t6:flush_pc", 32'(s_o_pc), 32'h0052);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
